// File: rtl/lbc_pkg.sv
// Shared state encoding and counter-width helpers for the local-bus burst controller.
package lbc_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ADDR = 4'b0010,
    S_DATA = 4'b0100,
    S_TURN = 4'b1000
  } lbc_state_t;

  // Retry counter is sized for the largest legal RETRY_MAX (15).
  localparam int RTY_W = 4;

  // Index/beat counter width; never narrower than one bit.
  function automatic int lbc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lbc_rr_arb.sv
// Round-robin channel search: first requester above the last owner, wrapping around.
module lbc_rr_arb #(
  parameter int NCH = 2,
  parameter int IW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  last,
  output logic [IW-1:0]  gnt,
  output logic           vld
);

  int             j;
  logic [NCH-1:0] hit;

  // Scan from farthest to nearest so the nearest requester above 'last' wins.
  always_comb begin
    gnt = last;
    vld = 1'b0;
    j   = 0;
    hit = '0;
    for (int i = NCH; i >= 1; i--) begin
      j = int'(last) + i;
      if (j >= NCH) j = j - NCH;
      hit = req >> j;
      if (hit[0]) begin
        gnt = IW'(j);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lbc_lbus_burst.sv
// Local-bus burst initiator: arbitrates core channels and runs single/line
// transfers with abort-driven retry; every output is registered.
module lbc_lbus_burst
  import lbc_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int BURST     = 4,
  parameter int RETRY_MAX = 7
) (
  input  logic                  BUSCLK,
  input  logic                  RESET_LR,
  input  logic [NCH-1:0]        CH_REQ,
  input  logic [NCH-1:0]        CH_RW,
  input  logic [NCH-1:0]        CH_LINE,
  output logic [NCH-1:0]        CH_ACK,
  output logic [NCH-1:0]        CH_ERR,
  input  logic                  LBUS_GNT,
  input  logic                  LBUS_FRAME,
  input  logic                  LBUS_IRDY,
  input  logic                  LBUS_TRDY,
  input  logic                  LBUS_ABORT,
  output logic                  LL_REQ,
  output logic                  LL_FRAME_LR,
  output logic                  LL_IRDY_LR,
  output logic                  LL_COE_LR,
  output logic                  LL_DOE_LR,
  input  logic                  LL_RDFULL,
  output logic                  LL_RDLOAD,
  output logic                  LL_WRSHIFT,
  output logic [lbc_w(NCH)-1:0] LL_CHSEL,
  output logic                  LL_IDLE_LR
);

  localparam int SW = lbc_w(NCH);
  localparam int CW = lbc_w(BURST);

  lbc_state_t       st, st_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [RTY_W-1:0] rty, rty_nx, rty_inc;
  logic             pend, pend_nx;
  logic             rw, rw_nx, line, line_nx;
  logic [SW-1:0]    own_nx, arb_gnt;
  logic             arb_vld;
  logic [NCH-1:0]   sel_oh, cur_oh, ack_nx, err_nx;
  logic             req_nx, frame_nx, irdy_nx, coe_nx, doe_nx;
  logic             rdload_nx, wrshift_nx;
  logic             go, acc, abort;

  lbc_rr_arb #(.NCH(NCH), .IW(SW)) u_arb (
    .req  (CH_REQ),
    .last (LL_CHSEL),
    .gnt  (arb_gnt),
    .vld  (arb_vld)
  );

  // A pending retry keeps the bus request alive even if the core dropped CH_REQ.
  assign go      = LL_REQ & LBUS_GNT & ~LBUS_FRAME & ~LBUS_IRDY & (arb_vld | pend);
  assign acc     = LBUS_TRDY & LL_IRDY_LR & ~LBUS_ABORT;
  assign abort   = LBUS_ABORT & ((st == S_ADDR) | (st == S_DATA));
  assign rty_inc = rty + RTY_W'(1);
  assign cur_oh  = NCH'(1) << LL_CHSEL;

  always_ff @(posedge BUSCLK or posedge RESET_LR) begin
    if (RESET_LR) st <= S_IDLE;
    else          st <= st_nx;
  end

  always_comb begin
    st_nx      = st;
    cnt_nx     = cnt;
    rty_nx     = rty;
    pend_nx    = pend;
    rw_nx      = rw;
    line_nx    = line;
    own_nx     = LL_CHSEL;
    sel_oh     = '0;
    ack_nx     = '0;
    err_nx     = '0;
    req_nx     = 1'b0;
    frame_nx   = 1'b0;
    irdy_nx    = 1'b0;
    coe_nx     = 1'b0;
    doe_nx     = 1'b0;
    rdload_nx  = 1'b0;
    wrshift_nx = 1'b0;

    unique case (st)
      S_IDLE: begin
        req_nx = (|CH_REQ) | pend;
        if (go) begin
          st_nx    = S_ADDR;
          req_nx   = 1'b0;
          own_nx   = pend ? LL_CHSEL : arb_gnt;
          sel_oh   = NCH'(1) << own_nx;
          rw_nx    = |(CH_RW & sel_oh);
          line_nx  = |(CH_LINE & sel_oh);
          frame_nx = 1'b1;
          coe_nx   = 1'b1;
          irdy_nx  = ~rw_nx;
          doe_nx   = ~rw_nx;
        end
      end
      S_ADDR: begin
        cnt_nx = line ? CW'(BURST - 1) : '0;
        if (!LBUS_ABORT) begin
          st_nx    = S_DATA;
          irdy_nx  = rw ? ~LL_RDFULL : 1'b1;
          doe_nx   = ~rw;
          frame_nx = ~((cnt_nx == '0) & irdy_nx);
        end
      end
      S_DATA: begin
        if (!LBUS_ABORT) begin
          if (acc && cnt == '0) begin
            st_nx      = S_TURN;
            ack_nx     = cur_oh;
            rdload_nx  = rw;
            wrshift_nx = ~rw;
            rty_nx     = '0;
            pend_nx    = 1'b0;
          end else begin
            if (acc) begin
              cnt_nx     = cnt - CW'(1);
              rdload_nx  = rw;
              wrshift_nx = ~rw;
            end
            irdy_nx  = rw ? ~LL_RDFULL : 1'b1;
            doe_nx   = ~rw;
            // FRAME drops together with the IRDY of the last beat.
            frame_nx = ~((cnt_nx == '0) & irdy_nx);
          end
        end
      end
      S_TURN:  st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase

    // Abort discards the in-flight beat and restarts the whole transfer later.
    if (abort) begin
      st_nx  = S_TURN;
      cnt_nx = '0;
      if (rty_inc >= RTY_W'(RETRY_MAX)) begin
        err_nx  = cur_oh;
        rty_nx  = '0;
        pend_nx = 1'b0;
      end else begin
        rty_nx  = rty_inc;
        pend_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge BUSCLK or posedge RESET_LR) begin
    if (RESET_LR) begin
      cnt         <= '0;
      rty         <= '0;
      pend        <= 1'b0;
      rw          <= 1'b0;
      line        <= 1'b0;
      LL_CHSEL    <= '0;
      LL_REQ      <= 1'b0;
      LL_FRAME_LR <= 1'b0;
      LL_IRDY_LR  <= 1'b0;
      LL_COE_LR   <= 1'b0;
      LL_DOE_LR   <= 1'b0;
      LL_RDLOAD   <= 1'b0;
      LL_WRSHIFT  <= 1'b0;
      LL_IDLE_LR  <= 1'b0;
      CH_ACK      <= '0;
      CH_ERR      <= '0;
    end else begin
      cnt         <= cnt_nx;
      rty         <= rty_nx;
      pend        <= pend_nx;
      rw          <= rw_nx;
      line        <= line_nx;
      LL_CHSEL    <= own_nx;
      LL_REQ      <= req_nx;
      LL_FRAME_LR <= frame_nx;
      LL_IRDY_LR  <= irdy_nx;
      LL_COE_LR   <= coe_nx;
      LL_DOE_LR   <= doe_nx;
      LL_RDLOAD   <= rdload_nx;
      LL_WRSHIFT  <= wrshift_nx;
      LL_IDLE_LR  <= (st_nx == S_IDLE);
      CH_ACK      <= ack_nx;
      CH_ERR      <= err_nx;
    end
  end

endmodule

// File: tb/tb_lbc_lbus_burst.sv
// Directed bench for lbc_lbus_burst (NCH=2, BURST=4, RETRY_MAX=2).
module tb_lbc_lbus_burst;

  localparam int NCH       = 2;
  localparam int BURST     = 4;
  localparam int RETRY_MAX = 2;

  logic           BUSCLK = 1'b0;
  logic           RESET_LR;
  logic [NCH-1:0] CH_REQ, CH_RW, CH_LINE, CH_ACK, CH_ERR;
  logic           LBUS_GNT, LBUS_FRAME, LBUS_IRDY, LBUS_TRDY, LBUS_ABORT;
  logic           LL_REQ, LL_FRAME_LR, LL_IRDY_LR, LL_COE_LR, LL_DOE_LR;
  logic           LL_RDFULL, LL_RDLOAD, LL_WRSHIFT, LL_IDLE_LR;
  logic [0:0]     LL_CHSEL;

  int errors = 0;
  int checks = 0;
  int n_rd, n_wr, n_ack, n_err;
  logic [NCH-1:0] last_ack, last_err;

  lbc_lbus_burst #(.NCH(NCH), .BURST(BURST), .RETRY_MAX(RETRY_MAX)) dut (
    .BUSCLK(BUSCLK), .RESET_LR(RESET_LR),
    .CH_REQ(CH_REQ), .CH_RW(CH_RW), .CH_LINE(CH_LINE),
    .CH_ACK(CH_ACK), .CH_ERR(CH_ERR),
    .LBUS_GNT(LBUS_GNT), .LBUS_FRAME(LBUS_FRAME), .LBUS_IRDY(LBUS_IRDY),
    .LBUS_TRDY(LBUS_TRDY), .LBUS_ABORT(LBUS_ABORT),
    .LL_REQ(LL_REQ), .LL_FRAME_LR(LL_FRAME_LR), .LL_IRDY_LR(LL_IRDY_LR),
    .LL_COE_LR(LL_COE_LR), .LL_DOE_LR(LL_DOE_LR),
    .LL_RDFULL(LL_RDFULL), .LL_RDLOAD(LL_RDLOAD), .LL_WRSHIFT(LL_WRSHIFT),
    .LL_CHSEL(LL_CHSEL), .LL_IDLE_LR(LL_IDLE_LR)
  );

  always #5 BUSCLK = ~BUSCLK;

  task automatic step();
    @(posedge BUSCLK);
    #1;
    if (LL_RDLOAD)  n_rd++;
    if (LL_WRSHIFT) n_wr++;
    if (|CH_ACK) begin n_ack++; last_ack = CH_ACK; end
    if (|CH_ERR) begin n_err++; last_err = CH_ERR; end
  endtask

  task automatic clr_cnt();
    n_rd = 0; n_wr = 0; n_ack = 0; n_err = 0;
    last_ack = '0; last_err = '0;
  endtask

  function automatic logic [12:0] all_out();
    return {CH_ACK, CH_ERR, LL_REQ, LL_FRAME_LR, LL_IRDY_LR, LL_COE_LR,
            LL_DOE_LR, LL_RDLOAD, LL_WRSHIFT, LL_CHSEL, LL_IDLE_LR};
  endfunction

  task automatic run_txn(input bit ch, input logic rw, input logic line,
                         input int n_abort, input int budget);
    int ab;
    int k;
    ab = n_abort;
    CH_REQ[ch] = 1'b1; CH_RW[ch] = rw; CH_LINE[ch] = line;
    for (k = 0; k < budget; k++) begin
      step();
      LBUS_ABORT = 1'b0;
      if (LL_COE_LR && ab > 0) begin LBUS_ABORT = 1'b1; ab--; end
      if (CH_ACK[ch] || CH_ERR[ch]) break;
    end
    CH_REQ[ch] = 1'b0;
    LBUS_ABORT = 1'b0;
    if (k >= budget) begin
      checks++; errors++;
      $display("FAIL txn_timeout ch=%0d no ACK/ERR within %0d cycles", ch, budget);
    end
  endtask

  task automatic test_reset();
    logic [12:0] zero = '0;
    RESET_LR = 1'b1;
    CH_REQ = '0; CH_RW = '0; CH_LINE = '0;
    LBUS_GNT = 1'b1; LBUS_FRAME = 1'b0; LBUS_IRDY = 1'b0;
    LBUS_TRDY = 1'b1; LBUS_ABORT = 1'b0; LL_RDFULL = 1'b0;
    clr_cnt();
    step(); step();
    checks++;
    if (all_out() !== zero) begin
      errors++; $display("FAIL reset_outputs got=%b want=%b", all_out(), zero);
    end
    RESET_LR = 1'b0;
    step();
    checks++;
    if (LL_IDLE_LR !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b want=1", LL_IDLE_LR); end
    checks++;
    if (LL_REQ !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", LL_REQ); end
  endtask

  // {LL_REQ, COE, FRAME, IRDY, RDLOAD, ACK[0]} per cycle after the request.
  task automatic test_line_read();
    logic [5:0] exp_tab [7] = '{6'b100000, 6'b011000, 6'b001100, 6'b001110,
                                6'b001110, 6'b000110, 6'b000011};
    logic [5:0] obs;
    clr_cnt();
    CH_REQ = 2'b01; CH_RW = 2'b01; CH_LINE = 2'b01;
    for (int s = 0; s < 7; s++) begin
      step();
      obs = {LL_REQ, LL_COE_LR, LL_FRAME_LR, LL_IRDY_LR, LL_RDLOAD, CH_ACK[0]};
      checks++;
      if (obs !== exp_tab[s]) begin
        errors++; $display("FAIL line_read_cyc%0d got=%b want=%b", s + 1, obs, exp_tab[s]);
      end
      if (s == 1) begin
        checks++;
        if (LL_CHSEL !== 1'b0) begin errors++; $display("FAIL line_read_chsel got=%0d want=0", LL_CHSEL); end
      end
    end
    CH_REQ = '0;
    step();
    checks++;
    if (n_rd !== 4) begin errors++; $display("FAIL line_read_loads got=%0d want=4", n_rd); end
    checks++;
    if (last_ack !== 2'b01 || n_ack !== 1) begin
      errors++; $display("FAIL line_read_ack got=%b/%0d want=01/1", last_ack, n_ack);
    end
    checks++;
    if (LL_IDLE_LR !== 1'b1) begin errors++; $display("FAIL line_read_idle got=%b want=1", LL_IDLE_LR); end
  endtask

  task automatic test_rdfull();
    int low;
    int s;
    low = 0;
    clr_cnt();
    CH_REQ = 2'b01; CH_RW = 2'b01; CH_LINE = 2'b01;
    for (s = 1; s <= 40; s++) begin
      step();
      if (LL_FRAME_LR && !LL_COE_LR && !LL_IRDY_LR) low++;
      LL_RDFULL = (s >= 4 && s <= 6);
      if (CH_ACK[0]) break;
    end
    CH_REQ = '0; LL_RDFULL = 1'b0;
    step();
    checks++;
    if (s > 40) begin errors++; $display("FAIL rdfull_timeout no ACK within 40 cycles"); end
    checks++;
    if (low !== 3) begin errors++; $display("FAIL rdfull_irdy_low got=%0d want=3", low); end
    checks++;
    if (n_rd !== 4) begin errors++; $display("FAIL rdfull_loads got=%0d want=4", n_rd); end
  endtask

  task automatic test_round_robin();
    logic [0:0] g [4];
    logic [0:0] exp_g [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [NCH-1:0] one = 2'b01;
    int ng;
    ng = 0;
    clr_cnt();
    CH_REQ = 2'b11; CH_RW = 2'b00; CH_LINE = 2'b00;
    for (int s = 0; s < 80 && n_ack < 4; s++) begin
      step();
      if (LL_COE_LR && ng < 4) begin g[ng] = LL_CHSEL; ng++; end
      if (|CH_ACK && ng > 0) begin
        checks++;
        if (CH_ACK !== (one << g[ng-1])) begin
          errors++; $display("FAIL rr_ack got=%b want=%b", CH_ACK, one << g[ng-1]);
        end
      end
    end
    CH_REQ = '0;
    step(); step();
    checks++;
    if (ng !== 4 || n_wr !== 4) begin
      errors++; $display("FAIL rr_count grants=%0d writes=%0d want=4/4", ng, n_wr);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g[i] !== exp_g[i]) begin
          errors++; $display("FAIL rr_grant%0d got=%0d want=%0d", i, g[i], exp_g[i]);
        end
      end
    end
  endtask

  task automatic test_abort_beat2();
    logic [7:0] bus;
    int s;
    clr_cnt();
    CH_REQ = 2'b01; CH_RW = 2'b00; CH_LINE = 2'b01;
    for (s = 0; s < 20 && n_wr == 0; s++) step();
    LBUS_ABORT = 1'b1;
    step();
    LBUS_ABORT = 1'b0;
    bus = {LL_REQ, LL_FRAME_LR, LL_IRDY_LR, LL_COE_LR, LL_DOE_LR, LL_WRSHIFT, CH_ACK[0], CH_ERR[0]};
    checks++;
    if (bus !== 8'h00 || LL_IDLE_LR !== 1'b0) begin
      errors++; $display("FAIL abort_turn got=%b idle=%b want=00000000 idle=0", bus, LL_IDLE_LR);
    end
    checks++;
    if (n_wr !== 1) begin errors++; $display("FAIL abort_pre_beats got=%0d want=1", n_wr); end
    for (s = 0; s < 40 && n_ack == 0; s++) step();
    CH_REQ = '0;
    step();
    checks++;
    if (n_wr !== 5) begin errors++; $display("FAIL abort_retry_beats got=%0d want=5", n_wr); end
    checks++;
    if (last_ack !== 2'b01 || n_err !== 0) begin
      errors++; $display("FAIL abort_retry_ack got=%b err=%0d want=01 err=0", last_ack, n_err);
    end
  endtask

  task automatic test_retry_error();
    clr_cnt();
    run_txn(1'b1, 1'b0, 1'b0, 2, 40);
    step();
    checks++;
    if (n_err !== 1 || last_err !== 2'b10) begin
      errors++; $display("FAIL retry_err got=%0d/%b want=1/10", n_err, last_err);
    end
    checks++;
    if (n_ack !== 0 || n_wr !== 0) begin
      errors++; $display("FAIL retry_err_noack ack=%0d wr=%0d want=0/0", n_ack, n_wr);
    end
    clr_cnt();
    run_txn(1'b1, 1'b0, 1'b0, 1, 40);
    step();
    checks++;
    if (n_err !== 0 || last_ack !== 2'b10 || n_wr !== 1) begin
      errors++; $display("FAIL retry_cleared err=%0d ack=%b wr=%0d want=0/10/1", n_err, last_ack, n_wr);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] zero = '0;
    int s;
    clr_cnt();
    CH_REQ = 2'b01; CH_RW = 2'b01; CH_LINE = 2'b01;
    for (s = 0; s < 20; s++) begin
      step();
      if (LL_FRAME_LR && LL_IRDY_LR && !LL_COE_LR) break;
    end
    checks++;
    if (s >= 20) begin errors++; $display("FAIL reset_mid_reach no DATA within 20 cycles"); end
    #2 RESET_LR = 1'b1;
    #1;
    checks++;
    if (all_out() !== zero) begin
      errors++; $display("FAIL reset_mid_async got=%b want=%b", all_out(), zero);
    end
    CH_REQ = '0;
    step();
    checks++;
    if (all_out() !== zero) begin
      errors++; $display("FAIL reset_mid_hold got=%b want=%b", all_out(), zero);
    end
    RESET_LR = 1'b0;
    step();
    checks++;
    if (LL_IDLE_LR !== 1'b1) begin errors++; $display("FAIL reset_mid_idle got=%b want=1", LL_IDLE_LR); end
    clr_cnt();
    run_txn(1'b0, 1'b0, 1'b0, 0, 30);
    step();
    checks++;
    if (n_wr !== 1 || last_ack !== 2'b01) begin
      errors++; $display("FAIL reset_mid_write wr=%0d ack=%b want=1/01", n_wr, last_ack);
    end
  endtask

  initial begin
    test_reset();
    test_line_read();
    test_rdfull();
    test_round_robin();
    test_abort_beat2();
    test_retry_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
